// File: rtl/fpdiv_iterative_if.sv
// Streaming val/rdy bundle for the iterative fixed-point divider.
//   recv_val/recv_rdy : operand handshake, a = dividend, b = divisor
//   send_val/send_rdy : result handshake, c = quotient, err = div-by-zero/overflow
// master = producer/consumer side (bench or upstream), slave = divider.
interface fpdiv_iterative_if #(
  parameter int n = 32
) ();
  logic         recv_val;
  logic         recv_rdy;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         send_val;
  logic         send_rdy;
  logic [n-1:0] c;
  logic         err;

  modport master (
    output recv_val, a, b, send_rdy,
    input  recv_rdy, send_val, c, err
  );

  modport slave (
    input  recv_val, a, b, send_rdy,
    output recv_rdy, send_val, c, err
  );
endinterface

// File: rtl/fpdiv_iterative.sv
// Iterative fixed-point divider, c = a / b, one quotient bit per cycle.
// Restoring division on magnitudes of an (n+d)-bit dividend |a| << d, so the
// quotient keeps d fraction bits. Result truncates toward zero and saturates
// (err=1) on overflow or divide-by-zero. Latency is fixed at n+d cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   io    : fpdiv_iterative_if.slave (recv a/b handshake, send c/err handshake)
// Parameters: n total width, d fraction bits, sign 1 = two's complement.
module fpdiv_iterative #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter bit sign = 1'b1
) (
  input logic             clk,
  input logic             reset,
  fpdiv_iterative_if.slave io
);

  localparam int QW = n + d;
  localparam int CW = $clog2(QW);

  // Quotient limits held at quotient width. With d=0 the unsigned limit
  // wraps to all-ones, which correctly makes unsigned overflow impossible.
  localparam logic [QW-1:0] ONE   = QW'(1);
  localparam logic [QW-1:0] LIM_U = (ONE << n) - ONE;
  localparam logic [QW-1:0] LIM_P = (ONE << (n-1)) - ONE;
  localparam logic [QW-1:0] LIM_N = ONE << (n-1);
  localparam logic [n-1:0]  MAX_P = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0]  MIN_N = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic            recv_rdy, send_val;
  logic            acc, fin;
  logic            sa, sb, zero;
  logic [n-1:0]    abs_a, abs_b, babs;
  logic [QW-1:0]   dvd, quo, quo_nx;
  // Remainder is always < |b| <= 2^n - 1, so n bits hold it between
  // iterations; only the shifted trial value needs the extra bit.
  logic [n-1:0]    rem, rem_nx;
  logic [n:0]      rem_sh;
  logic [CW-1:0]   cnt, idx;
  logic            ge, neg, ovf;
  logic [n-1:0]    res_c, c_r;
  logic            res_err, err_r;

  // ---------------- FSM next-state / handshake outputs ----------------
  always_comb begin
    state_nx = state;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (io.recv_val) state_nx = CALC;
      end
      CALC: if (cnt == CW'(QW-1)) state_nx = DONE;
      DONE: begin
        send_val = 1'b1;
        if (io.send_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign acc = (state == IDLE) && io.recv_val;
  assign fin = (state == CALC) && (cnt == CW'(QW-1));

  // Magnitudes; -(-2^(n-1)) wraps to 2^(n-1), which is the right unsigned value.
  assign abs_a = (sign && io.a[n-1]) ? -io.a : io.a;
  assign abs_b = (sign && io.b[n-1]) ? -io.b : io.b;

  // ---------------- one restoring step, MSB first ----------------
  always_comb begin
    idx    = CW'(QW-1) - cnt;
    rem_sh = {rem, dvd[idx]};
    ge     = rem_sh >= {1'b0, babs};
    rem_nx = ge ? (rem_sh[n-1:0] - babs) : rem_sh[n-1:0];
    quo_nx = quo;
    quo_nx[idx] = ge;
  end

  // ---------------- result formation from the final quotient ----------------
  always_comb begin
    neg = sa ^ sb;
    if (!sign)     ovf = quo_nx > LIM_U;
    else if (!neg) ovf = quo_nx > LIM_P;
    else           ovf = quo_nx > LIM_N;

    res_err = 1'b1;
    if (zero) begin
      // Divisor zero: direction follows the dividend only (0/0 -> max positive).
      res_c = !sign ? '1 : (sa ? MIN_N : MAX_P);
    end else if (ovf) begin
      res_c = !sign ? '1 : (neg ? MIN_N : MAX_P);
    end else begin
      res_c   = neg ? -quo_nx[n-1:0] : quo_nx[n-1:0];
      res_err = 1'b0;
    end
  end

  // ---------------- state / datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sa    <= 1'b0;
      sb    <= 1'b0;
      zero  <= 1'b0;
      babs  <= '0;
      dvd   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      c_r   <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        sa   <= sign & io.a[n-1];
        sb   <= sign & io.b[n-1];
        zero <= (io.b == '0);
        babs <= abs_b;
        dvd  <= QW'(abs_a) << d;
        rem  <= '0;
        quo  <= '0;
        cnt  <= '0;
      end else if (state == CALC) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= fin ? '0 : cnt + 1'b1;
        if (fin) begin
          c_r   <= res_c;
          err_r <= res_err;
        end
      end
    end
  end

  assign io.recv_rdy = recv_rdy;
  assign io.send_val = send_val;
  assign io.c        = c_r;
  assign io.err      = err_r;

endmodule

// File: doc/fpdiv_iterative.md
# fpdiv_iterative

Iterative fixed-point divider computing c = a / b on n-bit operands with d fraction bits, one quotient bit per cycle, using restoring division on magnitudes. It is the inverse-operation companion to the iterative fixed-point multiplier. It uses the same recv/send val/rdy streaming interface so the two can sit side by side in the fixed-point datapath.

## Interface
- n, 32, total operand/result bit width
- d, 16, fraction bits (0 ≤ d < n)
- sign, 1, 1 = two's-complement operands/result, 0 = unsigned
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- recv_val  input  1  operands a, b valid
- recv_rdy  output  1  block can accept operands
- a  input  n  dividend, fixed point
- b  input  n  divisor, fixed point
- send_val  output  1  result c valid
- send_rdy  input  1  consumer accepts c
- c  output  n  quotient, fixed point, truncated toward zero
- err  output  1  qualifies c: divide-by-zero or overflow (result saturated)

## Operation
- States: IDLE (recv_rdy=1, send_val=0), CALC (both 0), DONE (send_val=1, recv_rdy=0).
- IDLE → CALC on recv_val & recv_rdy:
  - register sa = sign & a[n-1] and sb = sign & b[n-1];
  - form magnitudes |a|, |b| (n bits unsigned; |−2^(n−1)| = 2^(n−1));
  - dividend D = |a| << d (n+d bits); clear remainder R (n+1 bits) and quotient Q (n+d bits);
  - set counter = 0 and zero = (b == 0).
- CALC, each cycle, MSB first:
  - R' = {R, D[n+d−1−counter]};
  - if R' ≥ |b|, set R = R' − |b| and Q bit = 1; else R = R', Q bit = 0;
  - counter increments; after n+d iterations → DONE.
- Result formation, on the final CALC edge:
  - neg = sa ^ sb;
  - unsigned (sign=0): overflow if Q ≥ 2^n;
  - signed, neg=0: overflow if Q > 2^(n−1)−1;
  - signed, neg=1: overflow if Q > 2^(n−1);
  - no overflow: c = neg ? −Q[n−1:0] : Q[n−1:0], err = 0;
  - overflow: c saturates to 2^n−1 (unsigned), 0x7FF…F (signed positive) or 0x800…0 (signed negative), err = 1;
  - zero=1: CALC still runs (fixed latency) and its quotient is ignored; c = all-ones (unsigned), 0x7FF…F if a ≥ 0, 0x800…0 if a < 0 (signed), err = 1. 0/0 gives the max-positive value.
- DONE → IDLE on send_val & send_rdy. c and err hold until the next result is registered.
- recv_val in CALC or DONE is ignored and operands are not captured. a and b may change after the accept edge.
- Width rules: the remainder never exceeds n+1 bits. All compare/subtract is unsigned. Negation is two's complement mod 2^n.

## Timing
- Reset (reset low, asynchronous) forces IDLE, recv_rdy=1, send_val=0, c=0, err=0, counter=0. Release is sampled synchronously.
- Reset during CALC or DONE aborts the operation: no send_val, and any pending result is lost.
- Accept edge E0. Iteration edges E1…E(n+d). send_val rises immediately after E(n+d), with c and err valid in that same cycle: 48 cycles for the default parameters.
- send_val stays high with c/err stable until the send handshake edge. After that edge, recv_rdy=1 and send_val=0.
- A new accept can occur at the earliest one cycle after the send handshake; no accept happens in the same cycle. Minimum initiation interval is n+d+2 cycles.
- Latency is independent of operand values, divide-by-zero and overflow.

## Test plan
- Defaults n=32, d=16, sign=1: a=0x00018000 (1.5), b=0x00008000 (0.5) → c=0x00030000, err=0, send_val exactly 48 cycles after the accept edge.
- Signed and truncation, run back-to-back:
  - a=0xFFFD0000 (−3.0), b=0x00020000 (2.0) → c=0xFFFE8000, err=0;
  - a=0x00010000, b=0x00030000 → c=0x00005555;
  - a=0xFFFF0000, b=0x00030000 → c=0xFFFFAAAB (truncate toward zero).
- Saturation:
  - a=0x00010000, b=0 → c=0x7FFFFFFF, err=1;
  - a=0xFFFF0000, b=0 → c=0x80000000, err=1;
  - a=0x40000000, b=0x00000100 → c=0x7FFFFFFF, err=1.
- Unsigned build (sign=0): a=0xFFFF0000, b=0x00020000 → c=0x7FFF8000, err=0; 48-cycle latency.
- Backpressure: hold send_rdy=0 for 10 cycles after send_val rises, and pulse recv_val with new operands during that time → c/err stable, recv_rdy=0, no capture; on send_rdy=1, recv_rdy returns the next cycle.
- Reset: assert reset mid-CALC (cycle 20) → outputs immediately return to reset values, no send_val. A subsequent operation after release completes correctly.
